// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO management master:
//   - start-of-frame (ST) and opcode (OP) codes for Clause 22 / Clause 45
//   - bit positions of the fields inside the 32-bit frame word
//   - frame FSM state type
//   - helpers that classify a frame word (valid / read-like)
// Configuration macro: MDIO_CL45_EN -- when defined, ST=00 (Clause 45) frames
// are accepted in addition to Clause 22 frames.
// -----------------------------------------------------------------------------
package mdio_pkg;

   // Start-of-frame codes
   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] ST_C45 = 2'b00;

   // Clause 22 opcodes
   localparam logic [1:0] OP_C22_WR   = 2'b01;
   localparam logic [1:0] OP_C22_RD   = 2'b10;
   // Clause 45 opcodes
   localparam logic [1:0] OP_C45_ADDR = 2'b00;
   localparam logic [1:0] OP_C45_WR   = 2'b01;
   localparam logic [1:0] OP_C45_RD   = 2'b11;
   localparam logic [1:0] OP_C45_PRIA = 2'b10;

   // Turnaround pattern the master drives on write-like frames
   localparam logic [1:0] TA_WR = 2'b10;

   // Frame word field positions
   localparam int ST_MSB   = 31;
   localparam int ST_LSB   = 30;
   localparam int OP_MSB   = 29;
   localparam int OP_LSB   = 28;
   localparam int HDR_MSB  = 31;   // ST,OP,PHYAD,REGAD: the 14 header bits
   localparam int HDR_LSB  = 18;
   localparam int TA_MSB   = 17;
   localparam int TA_LSB   = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

`ifdef MDIO_CL45_EN
   localparam logic C45_ENABLED = 1'b1;
`else
   localparam logic C45_ENABLED = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_t;

   // A frame is accepted for serialisation only with a known ST/OP pairing.
   function automatic logic frame_valid(input logic [1:0] st, input logic [1:0] op);
      logic c22_ok;
      logic c45_ok;
      c22_ok = (st == ST_C22) && ((op == OP_C22_WR) || (op == OP_C22_RD));
      c45_ok = (st == ST_C45) && ((op == OP_C45_ADDR) || (op == OP_C45_WR) ||
                                  (op == OP_C45_RD)   || (op == OP_C45_PRIA));
      return c22_ok || (C45_ENABLED && c45_ok);
   endfunction

   // OP[1]=1 marks every read-like opcode in both clauses (C22 10, C45 11/10).
   function automatic logic op_is_read(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// -----------------------------------------------------------------------------
// mdio_clk_div
// Generates MDC from clk while enabled: CLK_DIV clk low, then CLK_DIV clk high.
// When disabled (or in reset) MDC is held low and the phase counter cleared,
// so every frame starts with a full low half-period.
// Ports:
//   clk          in  clock
//   reset        in  synchronous active-high reset
//   i_en         in  divider enable (frame in progress)
//   o_mdc        out management clock
//   o_mdc_rise   out 1-cycle strobe: MDC goes 0->1 at this edge
//   o_mdc_fall   out 1-cycle strobe: MDC goes 1->0 at this edge
// -----------------------------------------------------------------------------
module mdio_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_mdc,
   output logic o_mdc_rise,
   output logic o_mdc_fall
);

   localparam int            CW       = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_mdc;
   logic          w_wrap;

   assign w_wrap = i_en && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset || !i_en) begin
         r_cnt <= '0;
         r_mdc <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_mdc <= ~r_mdc;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_mdc      = r_mdc;
   assign o_mdc_rise = w_wrap & ~r_mdc;
   assign o_mdc_fall = w_wrap &  r_mdc;

endmodule

// File: rtl/mdio_mgmt_master.sv
// -----------------------------------------------------------------------------
// mdio_mgmt_master
// MDIO (IEEE 802.3 Clause 22) management master. Accepts one 32-bit frame word
// per MDIO_START while idle, sends PRE_LEN preamble ones followed by
// ST,OP,PHYAD,REGAD,TA,DATA on MDIO_OUT, and captures 16 read bits from MDIO_IN.
// Parameters: CLK_DIV (MDC half-period in clk, >=1), PRE_LEN (0..32).
// Configuration macro: MDIO_CL45_EN -- also accept ST=00 (Clause 45) frames.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   MDIO_START   frame request (taken only while BUSY=0)
//   T_DATA[31:0] frame word {ST,OP,PHYAD,REGAD,TA,DATA}
//   MDIO_IN      serial data from PHY
//   MDC          management clock (low while idle)
//   MDIO_OUT     serial data to PHY, MDIO_OE drive enable
//   RD_DATA      last read data, DATA_RDY pulses when it updates
//   BUSY         frame in progress, FRAME_ERR pulses on a rejected request
// -----------------------------------------------------------------------------
module mdio_mgmt_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int PRE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        BUSY,
   output logic        FRAME_ERR
);

   if (CLK_DIV < 1 || PRE_LEN < 0 || PRE_LEN > 32) begin : g_param_err
      $error("mdio_mgmt_master: illegal CLK_DIV/PRE_LEN");
   end

   localparam logic [4:0] PRE_LAST  = (PRE_LEN > 0) ? 5'(PRE_LEN - 1) : 5'd0;
   localparam logic [4:0] HDR_LAST  = 5'd13;
   localparam logic [4:0] TA_LAST   = 5'd1;
   localparam logic [4:0] DATA_LAST = 5'd15;

   logic        w_mdc, w_rise, w_fall;
   mdio_state_t r_state, w_state_nxt;
   logic [4:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_tx, w_tx_nxt, w_tx_load, w_tx_shift;
   logic [15:0] r_rx;
   logic [15:0] r_rd_data, w_rd_data_nxt;
   logic        r_out, w_out_nxt;
   logic        r_oe, w_oe_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_is_rd, w_is_rd_nxt;
   logic        r_rdy, w_rdy_nxt;
   logic        r_err, w_err_nxt;
   logic [1:0]  w_st, w_op;
   logic        w_valid;
   logic        w_unused;

   mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk        (clk),
      .reset      (reset),
      .i_en       (r_busy),
      .o_mdc      (w_mdc),
      .o_mdc_rise (w_rise),
      .o_mdc_fall (w_fall)
   );

   assign w_st    = T_DATA[ST_MSB:ST_LSB];
   assign w_op    = T_DATA[OP_MSB:OP_LSB];
   assign w_valid = frame_valid(w_st, w_op);
   // The requested TA field is never sent: writes drive 1,0 and reads release.
   assign w_unused = ^T_DATA[TA_MSB:TA_LSB];

   // Read frames pad TA/DATA with ones so MDIO_OUT rests high while released.
   assign w_tx_load  = op_is_read(w_op) ?
                       {T_DATA[HDR_MSB:HDR_LSB], 18'h3FFFF} :
                       {T_DATA[HDR_MSB:HDR_LSB], TA_WR, T_DATA[DATA_MSB:DATA_LSB]};
   assign w_tx_shift = {r_tx[30:0], 1'b1};

   // ---- next-state / next-output: bits advance only on MDC falling edges ----
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_tx_nxt      = r_tx;
      w_out_nxt     = r_out;
      w_oe_nxt      = r_oe;
      w_busy_nxt    = r_busy;
      w_is_rd_nxt   = r_is_rd;
      w_rd_data_nxt = r_rd_data;
      w_rdy_nxt     = 1'b0;
      w_err_nxt     = 1'b0;

      case (r_state)
         IDLE, DONE: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
            w_out_nxt   = 1'b1;
            if (MDIO_START) begin
               if (w_valid) begin
                  w_tx_nxt    = w_tx_load;
                  w_is_rd_nxt = op_is_read(w_op);
                  w_busy_nxt  = 1'b1;
                  w_oe_nxt    = 1'b1;
                  w_cnt_nxt   = 5'd0;
                  if (PRE_LEN > 0) begin
                     w_state_nxt = PRE;
                     w_out_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = HDR;
                     w_out_nxt   = w_tx_load[31];
                  end
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         PRE: begin
            if (w_fall) begin
               if (r_cnt == PRE_LAST) begin
                  w_state_nxt = HDR;
                  w_cnt_nxt   = 5'd0;
                  w_out_nxt   = r_tx[31];
               end else begin
                  w_cnt_nxt = r_cnt + 5'd1;
               end
            end
         end
         HDR: begin
            if (w_fall) begin
               w_tx_nxt  = w_tx_shift;
               w_out_nxt = r_tx[30];
               if (r_cnt == HDR_LAST) begin
                  w_state_nxt = TA;
                  w_cnt_nxt   = 5'd0;
                  w_oe_nxt    = ~r_is_rd;   // reads hand the line to the PHY at TA
               end else begin
                  w_cnt_nxt = r_cnt + 5'd1;
               end
            end
         end
         TA: begin
            if (w_fall) begin
               w_tx_nxt  = w_tx_shift;
               w_out_nxt = r_tx[30];
               if (r_cnt == TA_LAST) begin
                  w_state_nxt = DATA;
                  w_cnt_nxt   = 5'd0;
               end else begin
                  w_cnt_nxt = r_cnt + 5'd1;
               end
            end
         end
         DATA: begin
            if (w_fall) begin
               if (r_cnt == DATA_LAST) begin
                  w_state_nxt = DONE;
                  w_busy_nxt  = 1'b0;
                  w_oe_nxt    = 1'b0;
                  w_out_nxt   = 1'b1;
                  if (r_is_rd) begin
                     w_rd_data_nxt = r_rx;
                     w_rdy_nxt     = 1'b1;
                  end
               end else begin
                  w_tx_nxt  = w_tx_shift;
                  w_out_nxt = r_tx[30];
                  w_cnt_nxt = r_cnt + 5'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---- control / output registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= 5'd0;
         r_out     <= 1'b1;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_is_rd   <= 1'b0;
         r_rd_data <= 16'd0;
         r_rdy     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_out     <= w_out_nxt;
         r_oe      <= w_oe_nxt;
         r_busy    <= w_busy_nxt;
         r_is_rd   <= w_is_rd_nxt;
         r_rd_data <= w_rd_data_nxt;
         r_rdy     <= w_rdy_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // ---- shift registers: TX advances with the FSM, RX samples on MDC rise ----
   always_ff @(posedge clk) begin
      r_tx <= w_tx_nxt;
      if (r_state == DATA && w_rise) begin
         r_rx <= {r_rx[14:0], MDIO_IN};
      end
   end

   assign MDC       = w_mdc;
   assign MDIO_OUT  = r_out;
   assign MDIO_OE   = r_oe;
   assign RD_DATA   = r_rd_data;
   assign DATA_RDY  = r_rdy;
   assign BUSY      = r_busy;
   assign FRAME_ERR = r_err;

endmodule

// File: tb/tb_mdio_mgmt_master.sv
module tb_mdio_mgmt_master;

   localparam int CLK_DIV   = 4;
   localparam int PRE_LEN   = 32;
   localparam int NBITS     = PRE_LEN + 32;
   localparam int HALF      = CLK_DIV;
   localparam int BITCYC    = 2 * CLK_DIV;
   localparam int FRAME_CYC = NBITS * BITCYC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MDIO_START = 1'b0;
   logic [31:0] T_DATA = 32'd0;
   logic        MDIO_IN = 1'b1;
   logic        MDC, MDIO_OUT, MDIO_OE, DATA_RDY, BUSY, FRAME_ERR;
   logic [15:0] RD_DATA;

   always #5 clk = ~clk;

   mdio_mgmt_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
      .clk(clk), .reset(reset), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
      .MDIO_IN(MDIO_IN), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
      .RD_DATA(RD_DATA), .DATA_RDY(DATA_RDY), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // A frame is a list of NBITS (value, drive) pairs; each bit occupies
   // BITCYC cycles with MDC low for the first HALF cycles.
   logic [15:0] phy_data = 16'h0;
   bit          m_armed = 0;
   bit          m_active = 0;
   int          m_c = 0;
   bit          m_bit[NBITS];
   bit          m_drv[NBITS];
   bit          m_isrd = 0;
   logic [15:0] m_phy = 0, m_rd = 0;
   bit          m_busy = 0, m_mdc = 0, m_out = 1, m_oe = 0, m_rdy = 0, m_err = 0;

   function automatic bit model_valid(input logic [31:0] w);
      if (w[31:30] == 2'b01) return (w[29:28] == 2'b01) || (w[29:28] == 2'b10);
`ifdef MDIO_CL45_EN
      if (w[31:30] == 2'b00) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic bit model_is_read(input logic [31:0] w);
      return (w[29:28] == 2'b10) || (w[31:30] == 2'b00 && w[29:28] == 2'b11);
   endfunction

   always @(posedge clk) begin : model
      bit prev_busy;
      int k;
      prev_busy = m_busy;
      if (reset) begin
         m_armed = 1; m_active = 0; m_busy = 0; m_mdc = 0; m_out = 1; m_oe = 0;
         m_rd = 0; m_rdy = 0; m_err = 0;
      end else begin
         m_rdy = 0; m_err = 0;
         if (m_active) begin
            m_c++;
            if (m_c == FRAME_CYC) begin
               m_active = 0; m_busy = 0; m_mdc = 0; m_oe = 0; m_out = 1;
               if (m_isrd) begin m_rd = m_phy; m_rdy = 1; end
            end
         end
         if (MDIO_START && !prev_busy) begin
            if (model_valid(T_DATA)) begin
               m_isrd = model_is_read(T_DATA);
               m_phy  = phy_data;
               for (int i = 0; i < PRE_LEN; i++) begin m_bit[i] = 1; m_drv[i] = 1; end
               for (int i = 0; i < 14; i++) begin m_bit[PRE_LEN+i] = T_DATA[31-i]; m_drv[PRE_LEN+i] = 1; end
               m_bit[PRE_LEN+14] = 1; m_bit[PRE_LEN+15] = 0;
               m_drv[PRE_LEN+14] = !m_isrd; m_drv[PRE_LEN+15] = !m_isrd;
               for (int i = 0; i < 16; i++) begin
                  m_bit[PRE_LEN+16+i] = T_DATA[15-i]; m_drv[PRE_LEN+16+i] = !m_isrd;
               end
               m_active = 1; m_c = 0;
            end else begin
               m_err = 1;
            end
         end
         if (m_active) begin
            k = m_c / BITCYC;
            m_busy = 1;
            m_mdc  = (m_c % BITCYC) >= HALF;
            m_out  = m_bit[k];
            m_oe   = m_drv[k];
         end
      end
   end

   // PHY: holds each read data bit for its whole bit period, junk elsewhere
   always @(negedge clk) begin : phy
      int k;
      k = m_c / BITCYC;
      if (m_active && m_isrd && k >= PRE_LEN + 16) MDIO_IN = m_phy[15 - (k - PRE_LEN - 16)];
      else MDIO_IN = 1'($urandom);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      if (m_armed) begin
         check("BUSY", BUSY, m_busy);
         check("MDC", MDC, m_mdc);
         check("MDIO_OE", MDIO_OE, m_oe);
         if (m_oe || !m_busy) check("MDIO_OUT", MDIO_OUT, m_out);
         check("RD_DATA", RD_DATA, m_rd);
         check("DATA_RDY", DATA_RDY, m_rdy);
         check("FRAME_ERR", FRAME_ERR, m_err);
      end
   end

   // ---------------- observation counters ----------------
   int          busy_cnt, rdy_cnt, err_cnt, rise_cnt, oe_cnt;
   logic [63:0] cap;
   logic        prev_mdc = 1'b0;

   always @(negedge clk) begin : monitor
      if (BUSY === 1'b1) busy_cnt++;
      if (DATA_RDY === 1'b1) rdy_cnt++;
      if (FRAME_ERR === 1'b1) err_cnt++;
      if (MDIO_OE === 1'b1) oe_cnt++;
      if (MDC === 1'b1 && prev_mdc === 1'b0) begin
         cap = {cap[62:0], MDIO_OUT};
         rise_cnt++;
      end
      prev_mdc = MDC;
   end

   task automatic clr();
      busy_cnt = 0; rdy_cnt = 0; err_cnt = 0; rise_cnt = 0; oe_cnt = 0; cap = '0;
   endtask

   task automatic send(input logic [31:0] w);
      @(posedge clk); #1;
      clr();
      T_DATA = w; MDIO_START = 1'b1;
      @(posedge clk); #1;
      MDIO_START = 1'b0; T_DATA = $urandom;
   endtask

   task automatic wait_done(input bit stay, output logic rdy_at_fall);
      bit seen;
      seen = 0; rdy_at_fall = 1'b0;
      for (int i = 0; i < FRAME_CYC + 64 && !seen; i++) begin
         @(negedge clk);
         if (BUSY === 1'b0) begin seen = 1; rdy_at_fall = DATA_RDY; end
      end
      if (!seen) check("busy_fall_timeout", BUSY, 0);
      if (!stay) begin @(posedge clk); #1; end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic        r;
      logic [31:0] w, w2;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_BUSY", BUSY, 0);
      check("rst_MDC", MDC, 0);
      check("rst_OE", MDIO_OE, 0);
      check("rst_OUT", MDIO_OUT, 1);
      check("rst_RD_DATA", RD_DATA, 0);

      // Directed write
      send(32'h5C6AF5B5);
      wait_done(0, r);
      check("wr_preamble", cap[63:32], 32'hFFFFFFFF);
      check("wr_frame", cap[31:0], 32'h5C6AF5B5);
      check("wr_busy_cycles", busy_cnt, 512);
      check("wr_oe_cycles", oe_cnt, 512);
      check("wr_rdy_count", rdy_cnt, 0);
      check("wr_mdc_rises", rise_cnt, 64);

      // Directed read
      phy_data = 16'hA5C3;
      send(32'h6FB246C4);
      wait_done(0, r);
      check("rd_preamble", cap[63:32], 32'hFFFFFFFF);
      check("rd_header", cap[31:18], 14'h1BEC);
      check("rd_data", RD_DATA, 16'hA5C3);
      check("rd_rdy_at_fall", r, 1);
      check("rd_rdy_count", rdy_cnt, 1);
      check("rd_oe_cycles", oe_cnt, 368);
      check("rd_busy_cycles", busy_cnt, 512);

      // Bad ST
      send(32'h9C78402B);
      @(negedge clk);
      check("bad_err_pulse", FRAME_ERR, 1);
      repeat (20) @(posedge clk);
      #1;
      check("bad_err_count", err_cnt, 1);
      check("bad_mdc_rises", rise_cnt, 0);
      check("bad_busy", busy_cnt, 0);
      check("bad_oe", oe_cnt, 0);

      // Clause 45 address frame
      send(32'h0C6A1234);
`ifdef MDIO_CL45_EN
      wait_done(0, r);
      check("c45_frame", cap[31:0], 32'h0C6A1234);
      check("c45_busy", busy_cnt, 512);
      check("c45_rdy_count", rdy_cnt, 0);
`else
      repeat (20) @(posedge clk);
      #1;
      check("c45_err_count", err_cnt, 1);
      check("c45_busy", busy_cnt, 0);
`endif

      // START while BUSY is ignored
      w = $urandom; w[31:28] = 4'b0101; w[17:16] = 2'b10;
      send(w);
      repeat (256) @(posedge clk);
      #1 MDIO_START = 1'b1; T_DATA = 32'h6FB246C4;
      @(posedge clk); #1 MDIO_START = 1'b0;
      wait_done(0, r);
      check("busy_start_frame", cap[31:0], w);
      check("busy_start_cycles", busy_cnt, 512);

      // Back-to-back: read, then write accepted on the BUSY-fall cycle
      phy_data = 16'h3C5A;
      w = $urandom; w[31:28] = 4'b0110;
      send(w);
      wait_done(1, r);
      check("b2b_rdy", r, 1);
      w2 = $urandom; w2[31:28] = 4'b0101; w2[17:16] = 2'b10;
      MDIO_START = 1'b1; T_DATA = w2;
      @(posedge clk); #1 MDIO_START = 1'b0;
      check("b2b_busy", BUSY, 1);
      check("b2b_rd_data", RD_DATA, 16'h3C5A);
      wait_done(0, r);
      check("b2b_frame", cap[31:0], w2);

      // Reset in the middle of a read (bit 20)
      phy_data = 16'h1234;
      send(32'h6FB246C4);
      repeat (20 * BITCYC) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_MDC", MDC, 0);
      check("mid_rst_OE", MDIO_OE, 0);
      check("mid_rst_BUSY", BUSY, 0);
      check("mid_rst_RD_DATA", RD_DATA, 0);
      check("mid_rst_OUT", MDIO_OUT, 1);
      @(posedge clk); #1 reset = 1'b0;
      repeat (FRAME_CYC) @(posedge clk);
      #1;
      check("mid_rst_no_rdy", rdy_cnt, 0);

      // Randomised frames
      for (int n = 0; n < 16; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         w = $urandom;
         if (kind < 4) w[31:28] = 4'b0101;
         else if (kind < 8) w[31:28] = 4'b0110;
         else if (kind == 9) w[31:30] = 2'b00;
         phy_data = 16'($urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         send(w);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 400)) @(posedge clk);
            #1 MDIO_START = 1'b1; T_DATA = $urandom;
            @(posedge clk); #1 MDIO_START = 1'b0;
         end
         if (model_valid(w)) wait_done(0, r);
         else repeat (3) @(posedge clk);
      end

      repeat (10) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
